// File: rtl/pipe_pkg.sv
// Shared pipeline package: stage-register FSM states and ARM control-field widths
// used to size the per-stage control buses.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  localparam int WB_EN_W    = 1;
  localparam int MEM_R_EN_W = 1;
  localparam int MEM_W_EN_W = 1;
  localparam int B_W        = 1;
  localparam int S_W        = 1;
  localparam int EXE_CMD_W  = 3;

  // ID->EXE carries every control bit; later stages carry progressively fewer.
  localparam int CTRL_ID_EXE_W  = WB_EN_W + MEM_R_EN_W + MEM_W_EN_W + B_W + S_W + EXE_CMD_W;
  localparam int CTRL_EXE_MEM_W = WB_EN_W + MEM_R_EN_W + MEM_W_EN_W;
  localparam int CTRL_MEM_WB_W  = WB_EN_W + MEM_R_EN_W;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Shared by the pipeline performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready back-pressure, synchronous flush and a
// saturating stall counter. Define PIPE_STAGE_SKID_EN for the two-entry skid build.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall_cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and an offered entry is held until it transfers.
  pipe_state_t       state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != PS_EMPTY);
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;

  // in_ready is registered so out_ready has no path to the upstream stage.
  assign in_ready = in_ready_q;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = PS_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d     = PS_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (in_fire) begin
            state_d     = PS_TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        PS_TWO: begin
          if (out_fire) begin
            state_d     = PS_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
    in_ready_d = (state_d != PS_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end
`else
  // Single entry: accept when empty or when the held entry leaves this cycle.
  assign in_ready = !out_valid | out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    if (flush) begin
      state_d     = PS_EMPTY;
      main_ctrl_d = '0;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d     = PS_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        PS_ONE: begin
          if (in_fire) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (out_fire) begin
            state_d = PS_EMPTY;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PS_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (stall_cnt_clr),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed phases plus random traffic against a
// queue-level reference model of the stage.
module tb_pipe_stage_reg;

  localparam int CTRL_W  = 8;
  localparam int DATA_W  = 128;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              stall_cnt_clr;
  logic [CNT_W-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: entries held by the stage (head first) plus the main register view.
  logic [CTRL_W+DATA_W-1:0] exp_q[$];
  logic [CTRL_W-1:0]        m_ctrl;
  logic [DATA_W-1:0]        m_data;
  int                       m_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_data     (out_data),
    .stall_cnt_clr(stall_cnt_clr),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_in_ready(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
    return exp_q.size() < 2;
`else
    return (exp_q.size() == 0) || ordy;
`endif
  endfunction

  task automatic model_reset;
    exp_q.delete();
    m_ctrl = '0;
    m_data = '0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs(input logic ordy);
    chk("out_valid", DATA_W'(out_valid), DATA_W'(exp_q.size() > 0));
    chk("out_ctrl",  DATA_W'(out_ctrl),  DATA_W'(m_ctrl));
    chk("out_data",  out_data,           m_data);
    chk("in_ready",  DATA_W'(in_ready),  DATA_W'(exp_in_ready(ordy)));
    chk("stall_cnt", DATA_W'(stall_cnt), DATA_W'(m_cnt));
  endtask

  // Drive one cycle from just after a falling edge, check, then advance the model.
  task automatic step(input logic iv, input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                      input logic ordy, input logic fl, input logic clr);
    logic in_f;
    logic out_f;
    in_valid      = iv;
    in_ctrl       = ic;
    in_data       = id;
    out_ready     = ordy;
    flush         = fl;
    stall_cnt_clr = clr;
    #1;
    check_outputs(ordy);
    in_f  = iv && exp_in_ready(ordy);
    out_f = (exp_q.size() > 0) && ordy;
    if (clr) m_cnt = 0;
    else if ((exp_q.size() > 0) && !ordy && (m_cnt < CNT_MAX)) m_cnt++;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      m_ctrl = '0;
    end else begin
      if (out_f) void'(exp_q.pop_front());
      if (in_f) exp_q.push_back({ic, id});
      if (exp_q.size() > 0) {m_ctrl, m_data} = exp_q[0];
    end
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; stall_cnt_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and an 8-entry stream at full throughput.
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, CTRL_W'($urandom), DATA_W'(i), 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_no_stall", DATA_W'(stall_cnt), '0);

    // Downstream stall with upstream still pushing, then release.
    step(1'b1, 8'h11, 128'h101, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h20 + 8'(i), 128'h200 + 128'(i), 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    end

    // Flush a full stage whose entries carry ctrl 0xFF.
    step(1'b1, 8'hFF, 128'h301, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 128'h302, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 128'h303, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_ctrl_zero", DATA_W'(out_ctrl), '0);

    // An input offered in the flush cycle must never reach the output.
    step(1'b1, 8'h5A, 128'hAA, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("flush_drop", DATA_W'(out_data === 128'hAA), '0);
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    end

    // Counter saturation and clear-during-stall.
    step(1'b1, 8'h42, 128'h400, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    end
    chk("stall_sat", DATA_W'(stall_cnt), DATA_W'(CNT_MAX));
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("stall_clr", DATA_W'(stall_cnt), '0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and counter clear.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), CTRL_W'($urandom), rand_data(),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 29) == 0));
    end

    // Asynchronous reset in the middle of a stalled stream.
    step(1'b1, 8'h77, 128'h501, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h78, 128'h502, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; in_ctrl = 8'h79; in_data = 128'h503; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", DATA_W'(out_valid), '0);
    chk("rst_out_ctrl",  DATA_W'(out_ctrl),  '0);
    chk("rst_out_data",  out_data,           '0);
    chk("rst_stall_cnt", DATA_W'(stall_cnt), '0);
    chk("rst_in_ready",  DATA_W'(in_ready),  DATA_W'(1'b1));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(($urandom_range(0, 1) != 0), CTRL_W'($urandom), rand_data(),
           ($urandom_range(0, 2) != 0), 1'b0, 1'b0);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that supersedes the fixed per-stage registers between IF/ID/EXE/MEM/WB. Carries a control field and a data field with a valid/ready handshake, giving real back-pressure instead of a global freeze. Supports a synchronous flush and an optional two-entry skid buffer. Keeps a saturating stall-cycle counter for performance inspection.

## Interface
- CTRL_W, 8, control bits (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD…); zeroed on flush
- DATA_W, 128, payload bits (PC, Val_Rn, Val_Rm, Imm24, shift operand…); held on flush
- CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous flush (branch taken / hazard squash)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_ctrl  in  CTRL_W  upstream control
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_ctrl  out  CTRL_W  presented control
- out_data  out  DATA_W  presented payload
- stall_cnt_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Accept: in_fire = in_valid & in_ready. Deliver: out_fire = out_valid & out_ready. Strict FIFO order, no loss, no duplication.
- FSM (skid build): PS_EMPTY, PS_ONE (main valid), PS_TWO (main + skid valid).
- PS_EMPTY: in_fire -> PS_ONE, main <= in.
- PS_ONE: in_fire & out_fire -> PS_ONE, main <= in. in_fire only -> PS_TWO, skid <= in. out_fire only -> PS_EMPTY.
- PS_TWO: in_ready = 0. out_fire -> PS_ONE, main <= skid.
- out_valid = state != PS_EMPTY. out_ctrl/out_data always come from main.
- flush, priority over every handshake: next state PS_EMPTY; main and skid ctrl <= 0; data registers hold. An input offered in the flush cycle is dropped, and a same-cycle out_fire still counts as delivered.
- Stall counter: stall_cnt_clr -> 0 (wins over increment). Otherwise it increments when out_valid & !out_ready and saturates at 2^CNT_W-1. Flush does not clear it.
- Reset values: state PS_EMPTY, out_valid 0, out_ctrl 0, out_data 0, skid regs 0, in_ready 1, stall_cnt 0. Reset mid-transfer discards both entries.

## Timing
- Latency: in_fire at edge N gives out_valid=1 with that entry after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle while out_ready=1.
- Skid build: in_ready is a pure register (= !skid_valid) with no combinational path from out_ready. Upstream may see in_ready=1 for one cycle after downstream stalls, and the skid absorbs that entry.
- Flush asserted in cycle N gives out_valid=0 and out_ctrl=0 in cycle N+1, and in_ready=1 in cycle N+1.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid FSM as above, with registered in_ready.
- Undefined: single entry (PS_EMPTY/PS_ONE only), in_ready = !out_valid | out_ready (combinational). Same latency, throughput, flush and counter behaviour.

## Structure
- Shared package pipe_pkg holds the state enum pipe_state_t {PS_EMPTY, PS_ONE, PS_TWO} and the ARM control-field width constants used to size CTRL_W per stage.
- One sub-module, sat_counter (CNT_W, clr, inc, saturating), implements stall_cnt and is reused by other performance counters.

## Test plan
- Stream of 8 entries with data 0x1..0x8 and out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, 1-cycle latency, stall_cnt=0.
- Skid build: out_ready low for 3 cycles while in_valid=1 -> exactly 2 entries held, in_ready=0, stall_cnt=3. After release, order is preserved.
- flush with state PS_TWO and ctrl=0xFF in both entries -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1, out_data unchanged.
- flush and in_valid in the same cycle with in_data=0xAA -> 0xAA never appears on out_data.
- CNT_W=4 with out_ready held low for 20 cycles -> stall_cnt=15. stall_cnt_clr together with a stall -> stall_cnt=0.
- rst asserted asynchronously mid-stream -> outputs immediately reset to out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, and in_ready=1.
